// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues SPI commands and drives spi_master framing.
// Optional write-ack responses are enabled by defining SPI_SEQ_WR_ACK_EN.
//
// Ports:
//   mclk, reset         clock, async active-high reset
//   cmd_*               command push port (valid/ready), rd_wr/addr/wdata
//   rsp_*               response port (valid/ready), rdata/addr/is_wr
//   fifo_level          current command FIFO occupancy
//   busy                sequencer is not idle
//   start, master_*     framing pins to spi_master
//   master_in_data      read data returned by spi_master
module spi_cmd_sequencer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_CYCLES = 18,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                          mclk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rd_wr,
    input  logic [6:0]                    cmd_addr,
    input  logic [7:0]                    cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [7:0]                    rsp_rdata,
    output logic [6:0]                    rsp_addr,
    output logic                          rsp_is_wr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          start,
    output logic                          master_rd_wr,
    output logic [6:0]                    master_address,
    output logic [7:0]                    master_out_data,
    input  logic [7:0]                    master_in_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FRAME,
        CAPTURE,
        GAP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // FIFO storage: {rd_wr, addr, wdata}
    logic [15:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  level;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    logic           master_rd_wr_q, master_rd_wr_d;
    logic [6:0]     master_address_q, master_address_d;
    logic [7:0]     master_out_data_q, master_out_data_d;

    logic           rsp_valid_q, rsp_valid_d;
    logic [7:0]     rsp_rdata_q, rsp_rdata_d;
    logic [6:0]     rsp_addr_q, rsp_addr_d;
`ifdef SPI_SEQ_WR_ACK_EN
    logic           rsp_is_wr_q, rsp_is_wr_d;
`endif

    // Wrap bit in the pointers makes full/empty unambiguous.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == PW'(FIFO_DEPTH));
    assign empty = (level == '0);

    // Push is gated by full only, so a same-cycle pop never frees a slot
    // for the incoming command.
    assign push = cmd_valid && !full;

    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);

    // Next-state and pop decision
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending response blocks the next frame so it is
                // never overwritten.
                if (!empty && !rsp_valid_q) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = FRAME;
                cnt_d   = CW'(FRAME_CYCLES - 1);
            end
            FRAME: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CAPTURE: begin
                state_d = GAP;
                cnt_d   = CW'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Master pin registers: loaded on pop, otherwise held so the last
    // command stays visible after completion.
    always_comb begin
        master_rd_wr_d    = master_rd_wr_q;
        master_address_d  = master_address_q;
        master_out_data_d = master_out_data_q;
        if (pop) begin
            {master_rd_wr_d, master_address_d, master_out_data_d} =
                mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // Response slot
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;
`ifdef SPI_SEQ_WR_ACK_EN
        rsp_is_wr_d = rsp_is_wr_q;
`endif
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (state_q == CAPTURE) begin
            if (master_rd_wr_q) begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = master_in_data;
                rsp_addr_d  = master_address_q;
`ifdef SPI_SEQ_WR_ACK_EN
                rsp_is_wr_d = 1'b0;
`endif
            end
`ifdef SPI_SEQ_WR_ACK_EN
            else begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 8'h00;
                rsp_addr_d  = master_address_q;
                rsp_is_wr_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_rd_wr, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            master_rd_wr_q    <= 1'b0;
            master_address_q  <= '0;
            master_out_data_q <= '0;
            rsp_valid_q       <= 1'b0;
            rsp_rdata_q       <= '0;
            rsp_addr_q        <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            master_rd_wr_q    <= master_rd_wr_d;
            master_address_q  <= master_address_d;
            master_out_data_q <= master_out_data_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_rdata_q       <= rsp_rdata_d;
            rsp_addr_q        <= rsp_addr_d;
        end
    end

`ifdef SPI_SEQ_WR_ACK_EN
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            rsp_is_wr_q <= 1'b0;
        end else begin
            rsp_is_wr_q <= rsp_is_wr_d;
        end
    end
    assign rsp_is_wr = rsp_is_wr_q;
`else
    assign rsp_is_wr = 1'b0;
`endif

    // start decodes straight from the state register so an async reset
    // drops it in the same instant.
    assign start           = (state_q == FRAME);
    assign busy            = (state_q != IDLE);
    assign cmd_ready       = !full;
    assign fifo_level      = level;
    assign master_rd_wr    = master_rd_wr_q;
    assign master_address  = master_address_q;
    assign master_out_data = master_out_data_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_addr        = rsp_addr_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed testbench for spi_cmd_sequencer (default parameters).
// Expected values are hand-derived from the frame timing.
module tb_spi_cmd_sequencer;

    logic       mclk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rd_wr;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic [6:0] rsp_addr;
    logic       rsp_is_wr;
    logic [2:0] fifo_level;
    logic       busy;
    logic       start;
    logic       master_rd_wr;
    logic [6:0] master_address;
    logic [7:0] master_out_data;
    logic [7:0] master_in_data;

    int checks = 0;
    int errors = 0;

`ifdef SPI_SEQ_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    spi_cmd_sequencer dut (
        .mclk            (mclk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_rd_wr       (cmd_rd_wr),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_addr        (rsp_addr),
        .rsp_is_wr       (rsp_is_wr),
        .fifo_level      (fifo_level),
        .busy            (busy),
        .start           (start),
        .master_rd_wr    (master_rd_wr),
        .master_address  (master_address),
        .master_out_data (master_out_data),
        .master_in_data  (master_in_data)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for start to rise, then counts start-high cycles
    // and confirms master_* stay fixed. Returns on the first low sample.
    task automatic run_frame(output int n, output bit held,
                             input logic rw, input logic [6:0] a,
                             input logic [7:0] d);
        n    = 0;
        held = 1'b1;
        for (int i = 0; i < 10 && !start; i++) tick();
        while (start && n < 40) begin
            n++;
            if (master_rd_wr !== rw || master_address !== a ||
                master_out_data !== d) held = 1'b0;
            tick();
        end
    endtask

    initial begin
        int n;
        bit held;
        bit stalled;

        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_rd_wr      = 1'b0;
        cmd_addr       = '0;
        cmd_wdata      = '0;
        rsp_ready      = 1'b0;
        master_in_data = '0;
        tick();
        tick();
        chk("rst_start", start, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_maddr", master_address, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_is_wr", rsp_is_wr, 0);
        reset = 1'b0;
        tick();

        // Single write frame
        cmd_valid = 1'b1;
        cmd_rd_wr = 1'b0;
        cmd_addr  = 7'h15;
        cmd_wdata = 8'hA5;
        tick();
        cmd_valid = 1'b0;
        chk("wr_level_push", fifo_level, 1);
        chk("wr_busy_idle", busy, 0);
        tick();
        chk("wr_load_busy", busy, 1);
        chk("wr_load_start", start, 0);
        chk("wr_load_addr", master_address, 7'h15);
        chk("wr_load_level", fifo_level, 0);
        run_frame(n, held, 1'b0, 7'h15, 8'hA5);
        chk("wr_frame_len", n, 18);
        chk("wr_frame_held", held, 1);
        chk("wr_capture_rsp", rsp_valid, 0);
        tick();
        chk("wr_gap1_rsp", rsp_valid, WR_ACK);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_gap2_busy", busy, 1);
        chk("wr_gap2_start", start, 0);
        tick();
        chk("wr_idle_busy", busy, 0);
        chk("wr_idle_rsp", rsp_valid, 0);

        // Single read frame
        master_in_data = 8'h3C;
        cmd_valid = 1'b1;
        cmd_rd_wr = 1'b1;
        cmd_addr  = 7'h2C;
        cmd_wdata = 8'h00;
        tick();
        cmd_valid = 1'b0;
        run_frame(n, held, 1'b1, 7'h2C, 8'h00);
        chk("rd_frame_len", n, 18);
        chk("rd_frame_held", held, 1);
        chk("rd_capture_rsp", rsp_valid, 0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 8'h3C);
        chk("rd_rsp_addr", rsp_addr, 7'h2C);
        chk("rd_rsp_is_wr", rsp_is_wr, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_rsp_clear", rsp_valid, 0);
        tick();
        chk("rd_idle_busy", busy, 0);

        // Fill the FIFO behind a read whose response is held off
        master_in_data = 8'h5A;
        cmd_valid = 1'b1;
        cmd_rd_wr = 1'b1;
        cmd_addr  = 7'h10;
        cmd_wdata = 8'h00;
        tick();
        chk("fill_l1", fifo_level, 1);
        cmd_rd_wr = 1'b0;
        cmd_addr  = 7'h20;
        cmd_wdata = 8'h01;
        tick();
        chk("fill_pushpop", fifo_level, 1);
        chk("fill_busy", busy, 1);
        cmd_addr  = 7'h21;
        cmd_wdata = 8'h02;
        tick();
        chk("fill_l2", fifo_level, 2);
        cmd_addr  = 7'h22;
        cmd_wdata = 8'h03;
        tick();
        chk("fill_l3", fifo_level, 3);
        cmd_addr  = 7'h23;
        cmd_wdata = 8'h04;
        tick();
        chk("fill_l4", fifo_level, 4);
        chk("fill_ready_low", cmd_ready, 0);
        // Sixth command stays offered while full
        cmd_addr  = 7'h30;
        cmd_wdata = 8'h06;
        run_frame(n, held, 1'b1, 7'h10, 8'h00);
        chk("fill_frame_held", held, 1);
        tick();
        chk("fill_rsp_valid", rsp_valid, 1);
        chk("fill_rsp_rdata", rsp_rdata, 8'h5A);
        chk("fill_rsp_addr", rsp_addr, 7'h10);
        stalled = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (start) stalled = 1'b0;
            tick();
        end
        chk("stall_no_start", stalled, 1);
        chk("stall_level", fifo_level, 4);
        chk("stall_ready", cmd_ready, 0);
        chk("stall_busy", busy, 0);
        chk("stall_rsp_held", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("drain_rsp_clear", rsp_valid, 0);
        chk("drain_level4", fifo_level, 4);
        tick();
        chk("full_pop_level", fifo_level, 3);
        chk("full_pop_busy", busy, 1);
        chk("full_pop_addr", master_address, 7'h20);
        chk("full_pop_wdata", master_out_data, 8'h01);
        cmd_valid = 1'b0;

        // Reset on the 10th start cycle
        tick();
        chk("mid_start1", start, 1);
        for (int i = 0; i < 9; i++) tick();
        chk("mid_start10", start, 1);
        reset = 1'b1;
        #1;
        chk("arst_start", start, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_rsp", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cmd_ready, 1);
        @(posedge mclk);
        #1;
        reset = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_level", fifo_level, 0);
        chk("post_rst_start", start, 0);

        // Full frame after reset
        master_in_data = 8'hC3;
        cmd_valid = 1'b1;
        cmd_rd_wr = 1'b1;
        cmd_addr  = 7'h33;
        cmd_wdata = 8'h00;
        tick();
        cmd_valid = 1'b0;
        run_frame(n, held, 1'b1, 7'h33, 8'h00);
        chk("prst_frame_len", n, 18);
        chk("prst_frame_held", held, 1);
        tick();
        chk("prst_rsp_valid", rsp_valid, 1);
        chk("prst_rsp_rdata", rsp_rdata, 8'hC3);
        chk("prst_rsp_addr", rsp_addr, 7'h33);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 10 && busy; i++) tick();
        chk("prst_idle", busy, 0);

        // Write response behaviour
        cmd_valid = 1'b1;
        cmd_rd_wr = 1'b0;
        cmd_addr  = 7'h01;
        cmd_wdata = 8'h77;
        tick();
        cmd_valid = 1'b0;
        run_frame(n, held, 1'b0, 7'h01, 8'h77);
        chk("ack_frame_len", n, 18);
        tick();
`ifdef SPI_SEQ_WR_ACK_EN
        chk("ack_valid", rsp_valid, 1);
        chk("ack_is_wr", rsp_is_wr, 1);
        chk("ack_rdata", rsp_rdata, 8'h00);
        chk("ack_addr", rsp_addr, 7'h01);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`else
        chk("noack_valid", rsp_valid, 0);
        chk("noack_is_wr", rsp_is_wr, 0);
        chk("noack_addr_kept", rsp_addr, 7'h33);
`endif
        for (int i = 0; i < 10 && busy; i++) tick();
        chk("end_idle", busy, 0);
        chk("end_maddr_kept", master_address, 7'h01);
        chk("end_mdata_kept", master_out_data, 8'h77);
        chk("end_start_low", start, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
